// File: rtl/ro_edge_counter_pkg.sv
// ro_edge_counter_pkg: shared states, default parameters and LFSR constants for ro_edge_counter
package ro_edge_counter_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

    localparam int N_RO_DEF       = 4;
    localparam int CNT_W_DEF      = 12;
    localparam int WIN_W_DEF      = 16;
    localparam int SETTLE_CYC_DEF = 8;

    // Galois right-shift mask for x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ro_edge_detect.sv
// ro_edge_detect: one oscillator path - 2-flop synchronizer, history flop, saturating edge counter
//   clk, rst_n   : system clock, async active-low reset
//   osc          : asynchronous oscillator output
//   clr          : synchronous clear of count and overflow
//   cnt_en       : count detected rises this cycle
//   count        : registered edge count
//   count_nxt    : value count takes at the next edge (lets the top register parity on the same edge)
//   overflow     : sticky, set when a rise arrives while the counter is already saturated
module ro_edge_detect #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             osc,
    input  logic             clr,
    input  logic             cnt_en,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nxt,
    output logic             overflow
);

    logic sync1, sync2, hist, rise, sat, ovf_nxt;

    assign rise = sync2 & ~hist;
    assign sat  = &count;

    always_comb begin
        count_nxt = clr ? '0 : (cnt_en && rise && !sat) ? count + 1'b1 : count;
        ovf_nxt   = clr ? 1'b0 : overflow | (cnt_en & rise & sat);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            hist     <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            sync1    <= osc;
            sync2    <= sync1;
            hist     <= sync2;
            count    <= count_nxt;
            overflow <= ovf_nxt;
        end
    end

endmodule

// File: rtl/ro_edge_counter.sv
// ro_edge_counter: ring-oscillator start control, windowed per-path edge counting and parity random bits
//   clk, rst_n          : system clock, async active-low reset
//   meas_req            : request a measurement (accepted in IDLE or DONE)
//   win_len, path_en    : window length (0 acts as 1) and path enables, latched on acceptance
//   osc_in              : asynchronous oscillator outputs
//   start               : oscillator start enables, high in SETTLE and MEASURE
//   busy                : high from acceptance until result_valid rises
//   result_valid        : results held until result_ack or a new meas_req
//   result_ack          : consumer acknowledge
//   count               : flat per-path counts, path i at [i*CNT_W +: CNT_W]
//   overflow            : per-path sticky saturation flag
//   rand_bits           : per-path parity of count, captured on DONE entry
// Build option RO_RAND_WHITEN_EN: XOR rand_bits with a 16-bit Galois LFSR stepped on each DONE entry.
module ro_edge_counter
    import ro_edge_counter_pkg::*;
#(
    parameter int N_RO       = N_RO_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int WIN_W      = WIN_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  meas_req,
    input  logic [WIN_W-1:0]      win_len,
    input  logic [N_RO-1:0]       path_en,
    input  logic [N_RO-1:0]       osc_in,
    output logic [N_RO-1:0]       start,
    output logic                  busy,
    output logic                  result_valid,
    input  logic                  result_ack,
    output logic [N_RO*CNT_W-1:0] count,
    output logic [N_RO-1:0]       overflow,
    output logic [N_RO-1:0]       rand_bits
);

    state_t state, state_nxt;
    logic [WIN_W-1:0] win_q, timer, timer_nxt;
    logic [N_RO-1:0] en_q, en_nxt, par, rand_nxt;
    logic [N_RO*CNT_W-1:0] count_nxt;
    logic accept, done_entry, run_nxt;

    assign accept     = meas_req && (state == IDLE || state == DONE);
    assign done_entry = (state == MEASURE) && (state_nxt == DONE);
    assign en_nxt     = accept ? path_en : en_q;
    assign run_nxt    = (state_nxt == SETTLE) || (state_nxt == MEASURE);

    // SETTLE runs SETTLE_CYC+1 cycles (timer counts down to 0 inclusive), MEASURE exactly win_q cycles
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        if (accept) begin
            state_nxt = SETTLE;
            timer_nxt = WIN_W'(SETTLE_CYC);
        end else if (state == DONE && result_ack) begin
            state_nxt = IDLE;
        end else if (state == SETTLE) begin
            state_nxt = (timer == '0) ? MEASURE : SETTLE;
            timer_nxt = (timer == '0) ? win_q - 1'b1 : timer - 1'b1;
        end else if (state == MEASURE) begin
            state_nxt = (timer == '0) ? DONE : MEASURE;
            timer_nxt = timer - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            win_q        <= '0;
            en_q         <= '0;
            start        <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            en_q         <= en_nxt;
            start        <= run_nxt ? en_nxt : '0;
            busy         <= run_nxt;
            result_valid <= (state_nxt == DONE);
            if (accept)
                win_q <= (win_len == '0) ? WIN_W'(1) : win_len;
        end
    end

    for (genvar i = 0; i < N_RO; i++) begin : g_path
        ro_edge_detect #(.CNT_W(CNT_W)) u_det (
            .clk       (clk),
            .rst_n     (rst_n),
            .osc       (osc_in[i]),
            .clr       (accept),
            .cnt_en    ((state == MEASURE) && en_q[i]),
            .count     (count[i*CNT_W +: CNT_W]),
            .count_nxt (count_nxt[i*CNT_W +: CNT_W]),
            .overflow  (overflow[i])
        );
    end

    // parity of the final count, taken from count_nxt so the last window cycle is included
    always_comb begin
        par = '0;
        for (int i = 0; i < N_RO; i++)
            par[i] = ^count_nxt[i*CNT_W +: CNT_W];
    end

`ifdef RO_RAND_WHITEN_EN
    logic [15:0] lfsr, lfsr_nxt;

    assign lfsr_nxt = lfsr_step(lfsr);
    assign rand_nxt = par ^ lfsr_nxt[N_RO-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= LFSR_SEED;
        else if (done_entry)
            lfsr <= lfsr_nxt;
    end
`else
    assign rand_nxt = par;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rand_bits <= '0;
        else if (done_entry)
            rand_bits <= rand_nxt;
    end

endmodule
